// File: rtl/nand_arbiter_if.sv
// Bundle between the NAND arbiter and its requesters plus the shared gate.
// The arbiter uses the slave modport; the requester/gate side uses master.
interface nand_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
);
    // Handshake: a requester holds req[i] as a level; the arbiter samples a_in[i]/b_in[i]
    // only on the edge it raises gnt[i], and returns result with a one-cycle ack[i] pulse.
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  a_in;
    logic [NREQ-1:0]  b_in;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  ack;
    logic             result;
    logic             gate_a;
    logic             gate_b;
    logic             gate_y;
    logic             busy;
    logic [CNT_W-1:0] toggle_cnt;
    logic [1:0]       fsm_state;

    modport master (
        output req, a_in, b_in, gate_y,
        input  gnt, ack, result, gate_a, gate_b, busy, toggle_cnt, fsm_state
    );

    modport slave (
        input  req, a_in, b_in, gate_y,
        output gnt, ack, result, gate_a, gate_b, busy, toggle_cnt, fsm_state
    );
endinterface

// File: rtl/nand_arbiter.sv
// Round-robin arbiter sequencing one shared NAND gate among NREQ requesters.
// Optional gate_y toggle counter enabled by NAND_ARB_POWER_CNT_EN.
module nand_arbiter #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          reset_L,
    nand_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   idx;
    logic            found;
    logic [SW-1:0]   cnt;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] ack;
    logic            result;
    logic            gate_a;
    logic            gate_b;
    logic            busy;

    // Search upward from ptr+1 with wrap, so the last winner ranks lowest.
    always_comb begin
        sel   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state  <= IDLE;
            ptr    <= PW'(NREQ - 1);
            cnt    <= '0;
            gnt    <= '0;
            ack    <= '0;
            result <= 1'b0;
            gate_a <= 1'b0;
            gate_b <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gate_a <= bus.a_in[sel];
                        gate_b <= bus.b_in[sel];
                        gnt    <= NREQ'(1) << sel;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        ptr    <= sel;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    // ptr still names the owner, so ack goes back to it.
                    if (cnt == SW'(SETTLE - 1)) begin
                        result <= bus.gate_y;
                        ack    <= NREQ'(1) << ptr;
                        gnt    <= '0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt;
    assign bus.ack       = ack;
    assign bus.result    = result;
    assign bus.gate_a    = gate_a;
    assign bus.gate_b    = gate_b;
    assign bus.busy      = busy;
    assign bus.fsm_state = state;

`ifdef NAND_ARB_POWER_CNT_EN
    logic             y_d;
    logic [CNT_W-1:0] tcnt;

    // y_d resets to 1 because the gate idles at NAND(0,0).
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            y_d  <= 1'b1;
            tcnt <= '0;
        end else begin
            y_d <= bus.gate_y;
            if ((bus.gate_y != y_d) && (tcnt != '1)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign bus.toggle_cnt = tcnt;
`else
    assign bus.toggle_cnt = '0;
`endif
endmodule

// File: tb/tb_nand_arbiter.sv
// Bench for nand_arbiter: table of single transactions plus hand sequences for
// timing, fairness, req drop, mid-transaction reset and gate toggle counting.
module tb_nand_arbiter;
    localparam int NREQ   = 4;
    localparam int SETTLE = 2;
    localparam int CNT_W  = 16;
    localparam int W      = NREQ + 1;
`ifdef NAND_ARB_POWER_CNT_EN
    localparam bit POWER = 1'b1;
`else
    localparam bit POWER = 1'b0;
`endif

    logic clk;
    logic reset_L;
    int   cyc;
    int   tests;
    int   fails;

    nand_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

    nand_arbiter #(.NREQ(NREQ), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    // Shared gate with 3 ns propagation delay against a 10 ns clock.
    assign #3 bus.gate_y = ~(bus.gate_a & bus.gate_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0]     exp_q[$];
    logic [NREQ-1:0]  prev_ack;
    logic [NREQ-1:0]  prev_gnt;
    logic             y_prev;
    int               tog_model;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] a;
        logic [NREQ-1:0] b;
        logic [NREQ-1:0] gnt;
        logic            ga;
        logic            gb;
        logic            res;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_gate(input logic ga, input logic gb);
        logic y;
        y = ~(ga & gb);
        if (y != y_prev) tog_model++;
        y_prev = y;
    endtask

    task automatic wait_gnt(input string name);
        int n;
        n = 0;
        while (bus.gnt == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_gnt_timeout"}, 32'(n < 20), 32'd1);
    endtask

    task automatic wait_gnt_low(input string name);
        int n;
        n = 0;
        while (bus.gnt != '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_gnt_low_timeout"}, 32'(n < 20), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_timeout"}, 32'(n < 20), 32'd1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L  = 1'b0;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (2) @(negedge clk);
        reset_L   = 1'b1;
        y_prev    = 1'b1;
        tog_model = 0;
    endtask

    // Scoreboard: every ack pops the expected {owner, result} pushed at grant time.
    always @(negedge clk) begin
        if (!reset_L) begin
            prev_ack = '0;
            prev_gnt = '0;
        end else begin
            chk("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
            chk("ack_onehot", 32'($onehot0(bus.ack)), 32'd1);
            if (bus.ack != '0) begin
                chk("ack_width", 32'(prev_ack), 32'd0);
                chk("ack_owner", 32'(bus.ack), 32'(prev_gnt));
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("sb_ack_result", 32'({bus.ack, bus.result}), 32'(e));
                end
            end
            prev_ack = bus.ack;
            prev_gnt = bus.gnt;
        end
    end

    initial begin
        int order[5];
        int t_prev;
        logic [NREQ-1:0] ea;
        logic [NREQ-1:0] eb;

        vecs[0] = '{req: 4'b1111, a: 4'b0010, b: 4'b0010, gnt: 4'b0010, ga: 1'b1, gb: 1'b1, res: 1'b0};
        vecs[1] = '{req: 4'b0011, a: 4'b0001, b: 4'b0000, gnt: 4'b0001, ga: 1'b1, gb: 1'b0, res: 1'b1};
        vecs[2] = '{req: 4'b1001, a: 4'b1000, b: 4'b1000, gnt: 4'b1000, ga: 1'b1, gb: 1'b1, res: 1'b0};
        vecs[3] = '{req: 4'b1000, a: 4'b0000, b: 4'b1000, gnt: 4'b1000, ga: 1'b0, gb: 1'b1, res: 1'b1};
        vecs[4] = '{req: 4'b0110, a: 4'b0100, b: 4'b0100, gnt: 4'b0010, ga: 1'b0, gb: 1'b0, res: 1'b1};
        vecs[5] = '{req: 4'b0110, a: 4'b0100, b: 4'b0100, gnt: 4'b0100, ga: 1'b1, gb: 1'b1, res: 1'b0};
        vecs[6] = '{req: 4'b0001, a: 4'b0000, b: 4'b0000, gnt: 4'b0001, ga: 1'b0, gb: 1'b0, res: 1'b1};
        order = '{0, 1, 2, 3, 0};

        cyc      = 0;
        tests    = 0;
        fails    = 0;
        prev_ack = '0;
        prev_gnt = '0;
        reset_L  = 1'b0;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        do_reset();

        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_gates", 32'({bus.gate_a, bus.gate_b}), 32'd0);
        chk("rst_state", 32'(bus.fsm_state), 32'd0);
        chk("rst_tog", 32'(bus.toggle_cnt), 32'd0);

        // Cycle-exact latency of the first transaction.
        bus.req  = 4'b0001;
        bus.a_in = 4'b0001;
        bus.b_in = 4'b0001;
        @(negedge clk);
        chk("t0_gnt", 32'(bus.gnt), 32'b0001);
        chk("t0_gates", 32'({bus.gate_a, bus.gate_b}), 32'b11);
        chk("t0_busy", 32'(bus.busy), 32'd1);
        chk("t0_ack_early", 32'(bus.ack), 32'd0);
        exp_q.push_back({4'b0001, 1'b0});
        note_gate(1'b1, 1'b1);
        bus.req = '0;
        @(negedge clk);
        chk("t1_ack_early", 32'(bus.ack), 32'd0);
        @(negedge clk);
        chk("t2_ack", 32'(bus.ack), 32'b0001);
        chk("t2_result", 32'(bus.result), 32'd0);
        chk("t2_gnt", 32'(bus.gnt), 32'd0);
        chk("t2_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("t3_ack", 32'(bus.ack), 32'd0);
        chk("t3_busy", 32'(bus.busy), 32'd0);

        // Table: one transaction per row, operands inverted after grant.
        for (int i = 0; i < 7; i++) begin
            bus.req  = vecs[i].req;
            bus.a_in = vecs[i].a;
            bus.b_in = vecs[i].b;
            wait_gnt($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d_gates", i), 32'({bus.gate_a, bus.gate_b}),
                32'({vecs[i].ga, vecs[i].gb}));
            exp_q.push_back({vecs[i].gnt, vecs[i].res});
            note_gate(vecs[i].ga, vecs[i].gb);
            bus.req  = '0;
            bus.a_in = ~vecs[i].a;
            bus.b_in = ~vecs[i].b;
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_hold", i), 32'({bus.gate_a, bus.gate_b}),
                32'({vecs[i].ga, vecs[i].gb}));
        end
        chk("table_tog", 32'(bus.toggle_cnt), POWER ? 32'(tog_model) : 32'd0);

        // All requesters pending: strict rotation spaced SETTLE+2 cycles.
        do_reset();
        ea = 4'b0101;
        eb = 4'b0111;
        bus.req  = 4'b1111;
        bus.a_in = ea;
        bus.b_in = eb;
        t_prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_gnt($sformatf("rr%0d", n));
            chk($sformatf("rr%0d_gnt", n), 32'(bus.gnt), 32'(4'b0001 << order[n]));
            if (n > 0) chk($sformatf("rr%0d_spacing", n), 32'(cyc - t_prev), 32'(SETTLE + 2));
            t_prev = cyc;
            exp_q.push_back({4'(4'b0001 << order[n]), ~(ea[order[n]] & eb[order[n]])});
            note_gate(ea[order[n]], eb[order[n]]);
            if (n == 4) bus.req = '0;
            wait_gnt_low($sformatf("rr%0d", n));
        end
        wait_idle("rr_end");

        // Owner drops req one cycle after its grant.
        bus.req  = 4'b0100;
        bus.a_in = 4'b0000;
        bus.b_in = 4'b0100;
        wait_gnt("drop");
        chk("drop_gnt", 32'(bus.gnt), 32'b0100);
        exp_q.push_back({4'b0100, 1'b1});
        note_gate(1'b0, 1'b1);
        @(negedge clk);
        bus.req = '0;
        wait_idle("drop");
        chk("drop_idle", 32'(bus.fsm_state), 32'd0);
        @(negedge clk);
        chk("drop_stay_idle", 32'(bus.fsm_state), 32'd0);
        chk("drop_result_hold", 32'(bus.result), 32'd1);

        // Reset during WAIT: everything clears, no ack, requester 0 wins next.
        bus.req  = 4'b0010;
        bus.a_in = 4'b0010;
        bus.b_in = 4'b0010;
        wait_gnt("mid");
        chk("mid_gnt", 32'(bus.gnt), 32'b0010);
        @(negedge clk);
        chk("mid_in_wait", 32'(bus.fsm_state), 32'd1);
        reset_L = 1'b0;
        bus.req = 4'b0011;
        #1;
        chk("mid_rst_outs", 32'({bus.gnt, bus.ack, bus.result, bus.gate_a, bus.gate_b, bus.busy}), 32'd0);
        chk("mid_rst_state", 32'(bus.fsm_state), 32'd0);
        chk("mid_rst_tog", 32'(bus.toggle_cnt), 32'd0);
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            chk("mid_no_ack", 32'(bus.ack), 32'd0);
        end
        reset_L   = 1'b1;
        y_prev    = 1'b1;
        tog_model = 0;
        wait_gnt("mid_after");
        chk("mid_after_gnt", 32'(bus.gnt), 32'b0001);
        exp_q.push_back({4'b0001, 1'b1});
        note_gate(1'b0, 1'b0);
        bus.req = '0;
        wait_idle("mid_after");

        // Toggle count over (1,1),(0,0),(1,1),(0,1) on requester 0.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            logic [1:0] ab;
            ab = (n == 0) ? 2'b11 : (n == 1) ? 2'b00 : (n == 2) ? 2'b11 : 2'b01;
            bus.req  = 4'b0001;
            bus.a_in = {3'b000, ab[1]};
            bus.b_in = {3'b000, ab[0]};
            wait_gnt($sformatf("tog%0d", n));
            chk($sformatf("tog%0d_gnt", n), 32'(bus.gnt), 32'b0001);
            exp_q.push_back({4'b0001, ~(ab[1] & ab[0])});
            note_gate(ab[1], ab[0]);
            bus.req = '0;
            wait_idle($sformatf("tog%0d", n));
        end
        chk("tog_cnt", 32'(bus.toggle_cnt), POWER ? 32'd4 : 32'd0);
        chk("tog_model", 32'(bus.toggle_cnt), POWER ? 32'(tog_model) : 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
